wave_crossfade: RTL and testbench

Parametrised successor to the two-frequency physics wrapper. Drives 2×NCH external wave_logic generators as two ping-pong banks. Each bank sums NCH frequency components into a single wave. The block keeps per-channel phase offsets across frames, switches banks only on a frame boundary once the newly loaded bank reports ready, and exponentially crossfades the player path from the old bank to the new one. It sits between keyboard decode, the wave_logic instances and the renderer.

---
 rtl/wave_crossfade_if.sv | 22 ++
 rtl/wave_crossfade.sv | 184 ++++++++++++++++++
 tb/tb_wave_crossfade.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_crossfade_if.sv
// Generator-side bus of wave_crossfade: 2*NCH wave_logic channels,
// bank0 in the low slices. master = crossfade block, slave = generators.
interface wave_crossfade_if #(
  parameter int NCH = 2
);
  logic [5*2*NCH-1:0]  gen_freq_id;
  logic [2*NCH-1:0]    gen_new_f;
  logic [10*2*NCH-1:0] gen_index;
  logic [10*2*NCH-1:0] gen_height;
  logic [11*2*NCH-1:0] gen_period;
  logic [2*NCH-1:0]    gen_ready;

  modport master (
    output gen_freq_id, gen_new_f, gen_index,
    input  gen_height, gen_period, gen_ready
  );

  modport slave (
    input  gen_freq_id, gen_new_f, gen_index,
    output gen_height, gen_period, gen_ready
  );
endinterface

// File: rtl/wave_crossfade.sv
// Ping-pong bank wave summer with frame-synchronous bank switch and
// exponential crossfade of the player path from old to new bank.
module wave_crossfade #(
  parameter int NCH   = 2,
  parameter int BASE  = 384,
  parameter int CSTEP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [10:0]      d_offset,
  input  logic [10:0]      hcount,
  input  logic [5*NCH-1:0] freq_ids_in,
  input  logic             new_f_in,
  wave_crossfade_if.master gen,
  output logic [9:0]       wave_profile,
  output logic [9:0]       player_profile,
  output logic             active_bank,
  output logic             switch_pending
);

  localparam int NG = 2 * NCH;
  localparam int SW = 10 + $clog2(NCH) + 2;
  localparam logic [4:0] UNUSED = 5'h1F;
  localparam logic [7:0] FMASK = 8'((1 << CSTEP) - 1);
  localparam logic signed [SW-1:0] MAXV = 1023;

  typedef enum logic {STEADY, LOADING} state_t;

  state_t      r_state;
  logic        r_bank;
  logic [4:0]  r_id   [NG];
  logic [NG-1:0] r_new_f;
  logic [NCH-1:0] r_mask;
  logic [10:0] r_off  [NG];
  logic [10:0] r_idx  [NG];
  logic [9:0]  r_sum  [2];
  logic        r_pb1;
  logic        r_pb2;
  logic [9:0]  r_wave;
  logic [9:0]  r_player;
  logic [9:0]  r_coeff;
  logic [7:0]  r_fcnt;

  logic [10:0] w_per  [NG];
  logic [9:0]  w_hgt  [NG];
  logic [10:0] w_on   [NG];
  logic [9:0]  w_s    [2];
  logic [NCH-1:0] w_unused;
  logic [NCH-1:0] w_rdy_ld;
  logic        w_full;
  logic        w_switch;

  for (genvar g = 0; g < NG; g++) begin : g_ch
    logic [10:0] w_dm;
    logic [10:0] w_d;
    logic [11:0] w_os;
    assign w_per[g] = gen.gen_period[11*g +: 11];
    assign w_hgt[g] = gen.gen_height[10*g +: 10];
    assign gen.gen_freq_id[5*g +: 5] = r_id[g];
    assign gen.gen_index[10*g +: 10] = r_idx[g][9:0];
    assign w_dm = w_per[g] - 11'd1;
    assign w_d  = (d_offset > w_dm) ? w_dm : d_offset;
    assign w_os = {1'b0, r_off[g]} + {1'b0, w_d};
    // single conditional subtract keeps the offset below the period
    assign w_on[g] = (w_os >= {1'b0, w_per[g]})
                   ? 11'(w_os - {1'b0, w_per[g]}) : w_os[10:0];
  end

  assign gen.gen_new_f = r_new_f;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_unused[c] = (r_bank ? r_id[c] : r_id[NCH+c]) == UNUSED;
    end
    w_rdy_ld = r_bank ? gen.gen_ready[NCH-1:0]
                      : gen.gen_ready[2*NCH-1:NCH];
  end

  assign w_full   = &(r_mask | w_unused);
  assign w_switch = (r_state == LOADING) && frame_tick
                 && !new_f_in && w_full;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      logic signed [SW-1:0] acc;
      acc = SW'(-(NCH - 1) * BASE);
      for (int c = 0; c < NCH; c++) begin
        acc = acc + ((r_id[b*NCH+c] == UNUSED)
                     ? SW'(BASE) : SW'(w_hgt[b*NCH+c]));
      end
      if (acc < 0)         w_s[b] = 10'd0;
      else if (acc > MAXV) w_s[b] = 10'd1023;
      else                 w_s[b] = acc[9:0];
    end
  end

  logic [9:0]  w_sa;
  logic [9:0]  w_so;
  logic [10:0] w_inv;
  logic [20:0] w_mix;
  logic [19:0] w_cm;
  logic [9:0]  w_cd;
  logic [7:0]  w_fn;
  logic        w_fade;

  assign w_sa  = r_sum[r_pb2];
  assign w_so  = r_sum[!r_pb2];
  assign w_inv = 11'd1024 - {1'b0, r_coeff};
  assign w_mix = {11'd0, w_sa} * {10'd0, w_inv}
               + {11'd0, w_so} * {11'd0, r_coeff};
  assign w_cm  = {10'd0, r_coeff} * 20'd724;
  assign w_cd  = (w_cm[19:10] < 10'd8) ? 10'd0 : w_cm[19:10];
  assign w_fn  = r_fcnt + 8'd1;
  assign w_fade = ((w_fn & FMASK) == 8'd0) && (r_coeff != 10'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= STEADY;
      r_bank   <= 1'b0;
      r_new_f  <= '0;
      r_mask   <= '0;
      r_pb1    <= 1'b0;
      r_pb2    <= 1'b0;
      r_wave   <= 10'(BASE);
      r_player <= 10'(BASE);
      r_coeff  <= '0;
      r_fcnt   <= '0;
      for (int g = 0; g < NG; g++) begin
        r_id[g]  <= UNUSED;
        r_off[g] <= '0;
        r_idx[g] <= '0;
      end
      for (int b = 0; b < 2; b++) r_sum[b] <= 10'(BASE);
    end else begin
      r_new_f <= '0;
      for (int g = 0; g < NG; g++) begin
        if (hcount == 11'd0)
          r_idx[g] <= r_off[g];
        else if (r_idx[g] == w_per[g] - 11'd1)
          r_idx[g] <= '0;
        else
          r_idx[g] <= r_idx[g] + 11'd1;
        if (frame_tick) r_off[g] <= w_on[g];
      end
      if (frame_tick) begin
        r_fcnt <= w_fn;
        if (w_fade) r_coeff <= w_cd;
      end
      // a new request always wins over a pending switch
      if (new_f_in) begin
        r_state <= LOADING;
        r_mask  <= '0;
        if (r_state == STEADY) r_coeff <= '0;
        for (int g = 0; g < NG; g++) begin
          if ((g >= NCH) == !r_bank) begin
            r_id[g]    <= freq_ids_in[5*(g%NCH) +: 5];
            r_new_f[g] <= 1'b1;
            r_off[g]   <= '0;
          end
        end
      end else if (r_state == LOADING) begin
        if (r_new_f == '0) r_mask <= r_mask | w_rdy_ld;
        if (w_switch) begin
          r_state <= STEADY;
          r_bank  <= !r_bank;
          r_coeff <= 10'd1023;
          r_fcnt  <= '0;
        end
      end
      if (hcount == 11'd0) r_pb1 <= r_bank;
      r_pb2 <= r_pb1;
      for (int b = 0; b < 2; b++) r_sum[b] <= w_s[b];
      r_wave   <= w_sa;
      r_player <= w_mix[19:10];
    end
  end

  assign wave_profile   = r_wave;
  assign player_profile = r_player;
  assign active_bank    = r_bank;
  assign switch_pending = (r_state == LOADING);

endmodule

// File: tb/tb_wave_crossfade.sv
// Scoreboard bench for wave_crossfade: NCH=2, BASE=384, CSTEP=0,
// all generator periods 100, heights driven per channel.
module tb_wave_crossfade;
  localparam int NCH = 2;
  localparam int BASE = 384;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic new_f_in = 1'b0;
  logic [10:0] d_offset = '0;
  logic [10:0] hcount = '0;
  logic [9:0] freq_ids_in = '1;
  logic [9:0] wave_profile;
  logic [9:0] player_profile;
  logic active_bank;
  logic switch_pending;
  logic [9:0] hgt [4];
  logic [3:0] rdy = '0;

  int n_pass = 0;
  int n_total = 0;
  logic [9:0] qw [$];
  logic [9:0] qp [$];
  logic [9:0] exp_w;
  logic [9:0] exp_p;

  wave_crossfade_if #(.NCH(NCH)) gif ();

  assign gif.gen_height = {hgt[3], hgt[2], hgt[1], hgt[0]};
  assign gif.gen_period = {4{11'd100}};
  assign gif.gen_ready  = rdy;

  wave_crossfade #(.NCH(NCH), .BASE(BASE), .CSTEP(0)) dut (
    .clock(clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .d_offset(d_offset),
    .hcount(hcount),
    .freq_ids_in(freq_ids_in),
    .new_f_in(new_f_in),
    .gen(gif),
    .wave_profile(wave_profile),
    .player_profile(player_profile),
    .active_bank(active_bank),
    .switch_pending(switch_pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic newf(input logic [9:0] ids);
    freq_ids_in = ids;
    new_f_in = 1'b1;
    step();
    new_f_in = 1'b0;
  endtask

  function automatic logic [9:0] mixf(input int sa, input int so,
                                      input int c);
    int t;
    t = (sa * (1024 - c) + so * c) >> 10;
    return t[9:0];
  endfunction

  // drive column c, push its expectation, pop the one due now
  task automatic pix(input int c, input int n, output bit v,
                     output logic [9:0] w, output logic [9:0] p);
    hcount = 11'(c);
    if (c < n) begin
      qw.push_back(exp_w);
      qp.push_back(exp_p);
    end
    step();
    v = (c >= 2) && (qw.size() > 0);
    w = '0;
    p = '0;
    if (v) begin
      w = qw.pop_front();
      p = qp.pop_front();
    end
  endtask

  task automatic test_reset();
    bit v;
    logic [9:0] w, p;
    for (int g = 0; g < 4; g++) hgt[g] = 10'd777;
    reset = 1'b1;
    step();
    step();
    n_total += 5;
    if (active_bank !== 1'b0 || switch_pending !== 1'b0)
      $display("FAIL reset_state bank=%0b pend=%0b want 0 0",
               active_bank, switch_pending);
    else n_pass++;
    if (gif.gen_new_f !== 4'b0)
      $display("FAIL reset_newf got %b want 0", gif.gen_new_f);
    else n_pass++;
    if (gif.gen_freq_id !== 20'hFFFFF)
      $display("FAIL reset_ids got %h want fffff", gif.gen_freq_id);
    else n_pass++;
    if (gif.gen_index !== 40'h0)
      $display("FAIL reset_index got %h want 0", gif.gen_index);
    else n_pass++;
    if (wave_profile !== 10'd384 || player_profile !== 10'd384)
      $display("FAIL reset_prof got %0d/%0d want 384/384",
               wave_profile, player_profile);
    else n_pass++;
    reset = 1'b0;
    exp_w = 10'd384;
    exp_p = 10'd384;
    for (int c = 0; c < 8; c++) begin
      pix(c, 6, v, w, p);
      if (v) begin
        n_total += 2;
        if (wave_profile !== w)
          $display("FAIL idle_wave got %0d want %0d", wave_profile, w);
        else n_pass++;
        if (player_profile !== p)
          $display("FAIL idle_player got %0d want %0d", player_profile, p);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load();
    bit v;
    logic [9:0] w, p;
    hgt[2] = 10'd400;
    newf({5'h1F, 5'd3});
    n_total += 3;
    if (gif.gen_new_f !== 4'b1100)
      $display("FAIL load_strobe got %b want 1100", gif.gen_new_f);
    else n_pass++;
    if (gif.gen_freq_id !== {5'h1F, 5'd3, 10'h3FF})
      $display("FAIL load_ids got %h want %h", gif.gen_freq_id,
               {5'h1F, 5'd3, 10'h3FF});
    else n_pass++;
    if (switch_pending !== 1'b1)
      $display("FAIL load_pending got %0b want 1", switch_pending);
    else n_pass++;
    step();
    n_total++;
    if (gif.gen_new_f !== 4'b0)
      $display("FAIL load_strobe_len got %b want 0", gif.gen_new_f);
    else n_pass++;
    repeat (20) step();
    tick();
    n_total++;
    if (active_bank !== 1'b0 || switch_pending !== 1'b1)
      $display("FAIL early_tick bank=%0b pend=%0b want 0 1",
               active_bank, switch_pending);
    else n_pass++;
    repeat (27) step();
    rdy = 4'b0100;
    step();
    rdy = 4'b0;
    step();
    tick();
    n_total++;
    if (active_bank !== 1'b1 || switch_pending !== 1'b0)
      $display("FAIL switch bank=%0b pend=%0b want 1 0",
               active_bank, switch_pending);
    else n_pass++;
    exp_w = 10'd400;
    exp_p = mixf(400, 384, 1023);
    for (int c = 0; c < 8; c++) begin
      pix(c, 6, v, w, p);
      if (v) begin
        n_total += 2;
        if (wave_profile !== w)
          $display("FAIL load_wave got %0d want %0d", wave_profile, w);
        else n_pass++;
        if (player_profile !== p)
          $display("FAIL load_player got %0d want %0d", player_profile, p);
        else n_pass++;
      end
    end
  endtask

  task automatic test_offsets();
    int eo [4] = '{30, 60, 90, 20};
    int qi [$];
    logic [9:0] e;
    d_offset = 11'd30;
    for (int k = 0; k < 4; k++) begin
      tick();
      d_offset = (k == 3) ? 11'd0 : 11'd30;
      hcount = 11'd0;
      step();
      e = 10'(eo[k]);
      n_total++;
      if (gif.gen_index !== {e, e, e, e})
        $display("FAIL offset_%0d got %h want %0d", k, gif.gen_index, e);
      else n_pass++;
    end
    for (int c = 0; c < 82; c++) begin
      hcount = 11'(c);
      qi.push_back((20 + c) % 100);
      step();
      e = 10'(qi.pop_front());
      n_total++;
      if (gif.gen_index[29:20] !== e)
        $display("FAIL index_col%0d got %0d want %0d", c,
                 gif.gen_index[29:20], e);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    hgt[0] = 10'd640;
    hgt[2] = 10'd384;
    newf({5'h1F, 5'd3});
    n_total++;
    if (gif.gen_new_f !== 4'b0011)
      $display("FAIL restart_strobe got %b want 0011", gif.gen_new_f);
    else n_pass++;
    repeat (2) step();
    rdy = 4'b0001;
    step();
    rdy = 4'b0;
    step();
    new_f_in = 1'b1;
    frame_tick = 1'b1;
    step();
    new_f_in = 1'b0;
    frame_tick = 1'b0;
    n_total += 2;
    if (active_bank !== 1'b1 || switch_pending !== 1'b1)
      $display("FAIL restart_prio bank=%0b pend=%0b want 1 1",
               active_bank, switch_pending);
    else n_pass++;
    if (gif.gen_new_f !== 4'b0011)
      $display("FAIL restart_restrobe got %b want 0011", gif.gen_new_f);
    else n_pass++;
    repeat (3) step();
    tick();
    n_total++;
    if (active_bank !== 1'b1)
      $display("FAIL restart_mask got %0b want 1", active_bank);
    else n_pass++;
    rdy = 4'b0001;
    step();
    rdy = 4'b0;
    step();
    tick();
    n_total++;
    if (active_bank !== 1'b0 || switch_pending !== 1'b0)
      $display("FAIL restart_switch bank=%0b pend=%0b want 0 0",
               active_bank, switch_pending);
    else n_pass++;
  endtask

  task automatic test_fade();
    bit v;
    logic [9:0] w, p;
    int cf = 1023;
    for (int k = 0; k < 20; k++) begin
      exp_w = 10'd640;
      exp_p = mixf(640, 384, cf);
      for (int c = 0; c < 5; c++) begin
        pix(c, 3, v, w, p);
        if (v) begin
          n_total += 2;
          if (wave_profile !== w)
            $display("FAIL fade_wave%0d got %0d want %0d", k,
                     wave_profile, w);
          else n_pass++;
          if (player_profile !== p)
            $display("FAIL fade_player%0d got %0d want %0d", k,
                     player_profile, p);
          else n_pass++;
        end
      end
      tick();
      cf = (cf * 724) >> 10;
      if (cf < 8) cf = 0;
    end
    hcount = 11'd0;
    repeat (3) step();
    n_total++;
    if (player_profile !== 10'd640)
      $display("FAIL fade_end got %0d want 640", player_profile);
    else n_pass++;
  endtask

  task automatic test_clamp();
    bit v;
    logic [9:0] w, p;
    hgt[2] = 10'd1023;
    hgt[3] = 10'd1023;
    newf({5'd4, 5'd3});
    repeat (2) step();
    rdy = 4'b1100;
    step();
    rdy = 4'b0;
    step();
    tick();
    n_total++;
    if (active_bank !== 1'b1)
      $display("FAIL clamp_switch got %0b want 1", active_bank);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        hgt[2] = 10'd0;
        hgt[3] = 10'd0;
      end
      exp_w = (r == 0) ? 10'd1023 : 10'd0;
      exp_p = mixf(int'(exp_w), 640, 1023);
      for (int c = 0; c < 6; c++) begin
        pix(c, 4, v, w, p);
        if (v) begin
          n_total += 2;
          if (wave_profile !== w)
            $display("FAIL clamp_wave%0d got %0d want %0d", r,
                     wave_profile, w);
          else n_pass++;
          if (player_profile !== p)
            $display("FAIL clamp_player%0d got %0d want %0d", r,
                     player_profile, p);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    newf({5'd2, 5'd2});
    n_total++;
    if (switch_pending !== 1'b1)
      $display("FAIL mid_pending got %0b want 1", switch_pending);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total += 3;
    if (active_bank !== 1'b0 || switch_pending !== 1'b0 ||
        gif.gen_new_f !== 4'b0)
      $display("FAIL mid_state bank=%0b pend=%0b newf=%b want 0 0 0",
               active_bank, switch_pending, gif.gen_new_f);
    else n_pass++;
    if (gif.gen_freq_id !== 20'hFFFFF)
      $display("FAIL mid_ids got %h want fffff", gif.gen_freq_id);
    else n_pass++;
    if (wave_profile !== 10'd384 || player_profile !== 10'd384)
      $display("FAIL mid_prof got %0d/%0d want 384/384",
               wave_profile, player_profile);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_offsets();
    test_restart();
    test_fade();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
